clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider with exact 50% duty cycle for both odd and even ratios.
- Uses a posedge counter plus a negedge half-cycle retimer, ORed, for odd ratios.
- Generalises the fixed-ratio odd divider: parametrised width, runtime ratio load with glitch-free switch at a period boundary, enable with clean stop, and a synchronous tick output.
- Sits in the clock-generation area; feeds low-rate peripheral clocks and clock-enable users.

Parameters:
- WIDTH, 8, bit width of the ratio and counter; legal ratio range 2..2^WIDTH-1.
- DEF_DIV, 9, ratio active after reset; must be within 2..2^WIDTH-1.

Ports:
- clk  input  1  source clock.
- rst  input  1  reset; synchronous to clk, active-high.
- en  input  1  run request; sampled on clk posedge.
- div_ratio  input  WIDTH  new divide ratio N; valid while div_load=1.
- div_load  input  1  one-cycle load strobe.
- div_busy  output  1  a loaded ratio is pending and not yet applied.
- div_err  output  1  one-cycle pulse: the load was rejected because div_ratio < 2.
- clk_out  output  1  divided clock, period N*Tclk, high time N/2*Tclk.
- clk_tick  output  1  one-cycle pulse in the clk domain at each clk_out rising edge.

Behaviour:
- Reset (rst=1 at a posedge):
  - state=IDLE, cnt=0, n_act=DEF_DIV, pending cleared, div_busy=0, div_err=0, pos_r=0.
  - The negedge flop neg_r also clears synchronously: rst is sampled on the clk negedge.
  - clk_out=0 and clk_tick=0 during and after reset until running.
- Definition: H = floor(n_act/2).
- States: IDLE, RUN.
- IDLE:
  - cnt=0, pos_r=0.
  - en=1 at a posedge -> RUN, cnt<=0, pos_r<=1.
- RUN:
  - cnt counts 0..n_act-1.
  - pos_r is registered from the next counter value: pos_r=1 exactly while cnt<H.
- Wrap (RUN and cnt==n_act-1):
  - If en=0 -> IDLE, pos_r<=0. A stop request mid-period always completes the current period; no runt pulses.
  - Otherwise cnt<=0 and pos_r<=1.
  - If pending is valid, n_act<=pending at this same edge, and pending clears (div_busy falls).
- neg_r:
  - On clk negedge, neg_r<=pos_r when n_act is odd; 0 when even.
  - clk_out = pos_r | neg_r.
  - Odd N: high time H+0.5 cycles. Even N: high time H cycles. Period N cycles in both cases.
- clk_tick = (state==RUN && cnt==0); coincides with the clk_out rising edge.
- Load:
  - div_load=1 with div_ratio>=2: pending<=div_ratio, div_busy<=1.
  - A later load before the wrap overwrites pending (latest wins).
  - div_load=1 with div_ratio<2: div_err=1 for one cycle; pending unchanged.
  - Load in IDLE: n_act<=div_ratio directly; pending is not used; div_busy stays 0.
  - Load coinciding with the wrap edge: not applied at that wrap. It becomes pending and applies at the next wrap.
  - Load coinciding with a wrap that has an older pending value: the older value applies now, the new value becomes pending.
- en toggling inside a period has no effect except at the wrap decision.
- rst mid-operation: all state returns to reset values at that posedge. clk_out may truncate; this is the only allowed runt.
- Ratio changes never alter the current period length.
- Counter is WIDTH bits; no overflow is possible because n_act <= 2^WIDTH-1.

Test Plan:
- Reset then en=1, default N=9 -> clk_out period 9 cycles, high 4.5 cycles (rise on posedge, fall on negedge); clk_tick every 9 cycles; div_busy=0.
- While running N=9: load 4 at cnt=3 -> div_busy=1 until the wrap; current period stays 9; following periods are 4 cycles, high 2 cycles; neg_r stays 0.
- Load 6 then 7 before a wrap -> first new period is 7; load 10 exactly on the wrap edge -> 10 takes effect one period later.
- Load div_ratio=1 and 0 -> div_err pulses 1 cycle each; n_act and div_busy unchanged.
- en=0 at cnt=2 with N=5 -> period completes (5 cycles, high 2.5); clk_out then stays 0 and state=IDLE; en=1 -> clk_out rises on the next posedge.
- rst=1 mid-high phase with N=9 -> clk_out=0 immediately after that posedge/negedge; n_act returns to 9; pending cleared.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with exact 50% duty cycle for odd and even ratios.
// Posedge counter/phase flop plus a negedge half-cycle retimer; ratio changes apply only at a period boundary.
module clk_div_prog #(
    parameter int WIDTH   = 8,
    parameter int DEF_DIV = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_ratio,
    input  logic             div_load,
    output logic             div_busy,
    output logic             div_err,
    output logic             clk_out,
    output logic             clk_tick
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_act_q, n_act_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             pos_q, pos_d;
    logic             neg_q, neg_d;

    logic [WIDTH-1:0] half;
    logic             wrap;
    logic             load_ok;
    logic             load_bad;

    assign half     = n_act_q >> 1;
    assign wrap     = (state_q == RUN) && (cnt_q == n_act_q - WIDTH'(1));
    assign load_ok  = div_load && (div_ratio >= WIDTH'(2));
    assign load_bad = div_load && (div_ratio <  WIDTH'(2));

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        n_act_d = n_act_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        err_d   = load_bad;
        pos_d   = pos_q;

        if (load_ok) begin
            pend_d = div_ratio;
        end

        case (state_q)
            IDLE: begin
                // Stopped: a load takes effect at once; a value left pending by a stopping wrap lands here too.
                cnt_d  = '0;
                pos_d  = 1'b0;
                busy_d = 1'b0;
                if (load_ok) begin
                    n_act_d = div_ratio;
                end else if (busy_q) begin
                    n_act_d = pend_q;
                end
                if (en) begin
                    state_d = RUN;
                    pos_d   = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_d  = '0;
                    // An older pending ratio lands now; a load on this same edge waits for the next wrap.
                    if (busy_q) begin
                        n_act_d = pend_q;
                    end
                    busy_d = load_ok;
                    if (en) begin
                        pos_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        pos_d   = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_q + WIDTH'(1);
                    pos_d  = (cnt_d < half);
                    busy_d = busy_q | load_ok;
                end
            end
            default: state_d = IDLE;
        endcase

        // Odd ratios stretch the high phase by half a source cycle.
        neg_d = n_act_q[0] & pos_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_act_q <= WIDTH'(DEF_DIV);
            pend_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            pos_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_act_q <= n_act_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            pos_q   <= pos_d;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign clk_out  = pos_q | neg_q;
    assign clk_tick = (state_q == RUN) && (cnt_q == '0);
    assign div_busy = busy_q;
    assign div_err  = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a vector table for start-up and a mid-period load,
// plus hand-written sequences for double loads, wrap-edge loads, rejected loads, clean stop and reset.
module tb_clk_div_prog;

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [7:0] ratio;
        logic       hi;
        logic       lo;
        logic       tick;
        logic       busy;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] div_ratio = 8'd0;
    logic       div_load = 1'b0;
    logic       div_busy, div_err, clk_out, clk_tick;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    clk_div_prog #(.WIDTH(8), .DEF_DIV(9)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_ratio(div_ratio),
        .div_load (div_load),
        .div_busy (div_busy),
        .div_err  (div_err),
        .clk_out  (clk_out),
        .clk_tick (clk_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then check outputs after the posedge and after the following negedge.
    task automatic apply(input logic r, input logic e, input logic l, input logic [7:0] ra,
                         input logic hi, input logic lo, input logic tk, input logic bz,
                         input logic er, input bit chk_hi, input string tag);
        rst       = r;
        en        = e;
        div_load  = l;
        div_ratio = ra;
        @(posedge clk);
        #2;
        if (chk_hi) check({tag, "_clk_out_hi"}, clk_out, hi);
        check({tag, "_tick"}, clk_tick, tk);
        check({tag, "_busy"}, div_busy, bz);
        check({tag, "_err"}, div_err, er);
        @(negedge clk);
        #2;
        check({tag, "_clk_out_lo"}, clk_out, lo);
    endtask

    // Expected clk_out in the counter cycle k of a period n: high k<H, plus the first half of cycle H for odd n.
    function automatic logic exp_hi(input int n, input int k);
        return (k < n / 2) || ((n % 2 == 1) && (k == n / 2));
    endfunction

    function automatic logic exp_lo(input int n, input int k);
        return (k < n / 2);
    endfunction

    task automatic run_cycles(input int n, input int k0, input int cnt, input logic e,
                              input logic bz, input string tag);
        for (int i = 0; i < cnt; i++) begin
            int k;
            k = (k0 + i) % n;
            apply(1'b0, e, 1'b0, 8'd0, exp_hi(n, k), exp_lo(n, k), (k == 0), bz, 1'b0, 1'b1,
                  $sformatf("%s_n%0d_k%0d", tag, n, k));
        end
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic l, input logic [7:0] ra,
                                input logic hi, input logic lo, input logic tk, input logic bz,
                                input logic er);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.ratio = ra;
        v.hi = hi; v.lo = lo; v.tick = tk; v.busy = bz; v.err = er;
        return v;
    endfunction

    initial begin
        // Reset, idle, then run at the default N=9 (high 4.5 cycles); load 4 at cnt=3 of the second period.
        vecs.push_back(mk(1, 0, 0, 8'd0, 0, 0, 0, 0, 0));  // reset
        vecs.push_back(mk(1, 1, 0, 8'd0, 0, 0, 0, 0, 0));  // en ignored in reset
        vecs.push_back(mk(0, 0, 0, 8'd0, 0, 0, 0, 0, 0));  // idle
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 1, 1, 0, 0));  // cnt0, rises on posedge
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 1, 0, 0, 0));  // cnt1
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 1, 0, 0, 0));  // cnt2
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 1, 0, 0, 0));  // cnt3
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 0, 0, 0, 0));  // cnt4, falls on negedge
        vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 0, 0));  // cnt5
        vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 0, 0));  // cnt6
        vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 0, 0));  // cnt7
        vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 0, 0));  // cnt8
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 1, 1, 0, 0));  // cnt0, period 9
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 1, 0, 0, 0));  // cnt1
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 1, 0, 0, 0));  // cnt2
        vecs.push_back(mk(0, 1, 1, 8'd4, 1, 1, 0, 1, 0));  // cnt3, load 4 -> busy
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 0, 0, 1, 0));  // cnt4, period still 9
        vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 1, 0));  // cnt5
        vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 1, 0));  // cnt6
        vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 1, 0));  // cnt7
        vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 1, 0));  // cnt8
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 1, 1, 0, 0));  // wrap: N=4 applied, busy falls
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 1, 0, 0, 0));  // cnt1
        vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 0, 0));  // cnt2, even: no half-cycle stretch
        vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 0, 0));  // cnt3
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 1, 1, 0, 0));  // cnt0, period 4
        vecs.push_back(mk(0, 1, 0, 8'd0, 1, 1, 0, 0, 0));  // cnt1
        vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 0, 0));  // cnt2
        vecs.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 0, 0));  // cnt3

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].ratio, vecs[i].hi, vecs[i].lo,
                  vecs[i].tick, vecs[i].busy, vecs[i].err, 1'b1, $sformatf("vec%0d", i));
        end

        // Load 6 then 7 mid-period: latest wins, first new period is 7.
        apply(0, 1, 0, 8'd0, 1, 1, 1, 0, 0, 1, "dbl_k0");
        apply(0, 1, 1, 8'd6, 1, 1, 0, 1, 0, 1, "dbl_load6");
        apply(0, 1, 1, 8'd7, 0, 0, 0, 1, 0, 1, "dbl_load7");
        apply(0, 1, 0, 8'd0, 0, 0, 0, 1, 0, 1, "dbl_k3");
        apply(0, 1, 0, 8'd0, 1, 1, 1, 0, 0, 1, "dbl_wrap7");
        run_cycles(7, 1, 6, 1'b1, 1'b0, "n7");

        // Load 10 on the wrap edge: stays pending for one more 7-cycle period.
        apply(0, 1, 1, 8'd10, 1, 1, 1, 1, 0, 1, "wrapload10");
        run_cycles(7, 1, 6, 1'b1, 1'b1, "n7pend");
        apply(0, 1, 0, 8'd0, 1, 1, 1, 0, 0, 1, "wrap10");
        run_cycles(10, 1, 9, 1'b1, 1'b0, "n10");

        // Rejected loads: err pulses, ratio and busy unchanged.
        apply(0, 1, 1, 8'd1, 1, 1, 1, 0, 1, 1, "err_r1");
        apply(0, 1, 1, 8'd0, 1, 1, 0, 0, 1, 1, "err_r0");
        run_cycles(10, 2, 8, 1'b1, 1'b0, "posterr");
        run_cycles(10, 0, 10, 1'b1, 1'b0, "posterr_full");

        // Stop at a wrap, load 5 while idle, restart, then drop en at cnt=2 and let the period finish.
        apply(0, 0, 0, 8'd0, 0, 0, 0, 0, 0, 1, "stop10");
        apply(0, 0, 1, 8'd5, 0, 0, 0, 0, 0, 1, "idle_load5");
        apply(0, 1, 0, 8'd0, 1, 1, 1, 0, 0, 1, "start5");
        run_cycles(5, 1, 1, 1'b1, 1'b0, "n5");
        run_cycles(5, 2, 3, 1'b0, 1'b0, "n5stop");
        apply(0, 0, 0, 8'd0, 0, 0, 0, 0, 0, 1, "idle_a");
        apply(0, 0, 0, 8'd0, 0, 0, 0, 0, 0, 1, "idle_b");
        apply(0, 1, 0, 8'd0, 1, 1, 1, 0, 0, 1, "restart5");

        // Reset mid-high with a pending load: ratio returns to 9, pending dropped.
        apply(0, 1, 1, 8'd3, 1, 1, 0, 1, 0, 1, "rst_pre_load3");
        apply(1, 1, 0, 8'd0, 0, 0, 0, 0, 0, 0, "rst_mid");
        apply(0, 1, 0, 8'd0, 1, 1, 1, 0, 0, 1, "rst_restart");
        run_cycles(9, 1, 8, 1'b1, 1'b0, "postrst");
        run_cycles(9, 0, 9, 1'b1, 1'b0, "postrst_full");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
